fdiv_scheduler: RTL and testbench
=================================

# fdiv_scheduler

Sequencer and round-robin arbiter that shares one single-precision floating-point divider among `NREQ` requesters. It accepts one divide request at a time over a valid/ready handshake and drives the divider operands stable for `DIV_LAT` cycles. It captures the quotient and returns it with the requester's index over a response handshake. Divide-by-zero cases bypass the divider. The block sits between the core's FPU issue logic and the divider datapath.

## Interface
- `XLEN`, 32, operand/result width (IEEE-754 single precision only)
- `NREQ`, 2, number of requesters (≥2)
- `DIV_LAT`, 4, cycles the divider needs with stable operands before its result is valid (≥1)
- `IDW`, `$clog2(NREQ)`, requester-index width (derived)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  per-requester request valid
- `req_ready`  out  NREQ  per-requester accept (one-hot or zero)
- `req_a`  in  NREQ*XLEN  dividends, requester i at bits [i*XLEN +: XLEN]
- `req_b`  in  NREQ*XLEN  divisors, same packing
- `div_a`  out  XLEN  operand A to divider
- `div_b`  out  XLEN  operand B to divider
- `div_result`  in  XLEN  divider quotient
- `resp_valid`  out  1  response valid
- `resp_ready`  in  1  response consumer ready
- `resp_data`  out  XLEN  quotient
- `resp_id`  out  IDW  index of the requester that owns `resp_data`

## Operation
- States:
  - IDLE: waiting for a request
  - EXEC: divider busy
  - RESP: holding the response
- IDLE:
  - The grant is round-robin, starting at `last+1` and wrapping modulo NREQ.
  - `req_ready[g]=1` only for the granted valid requester. This is combinational from `req_valid` and `last`.
  - Accept occurs when `req_valid[g]&req_ready[g]`. On accept: latch `req_a[g]`, `req_b[g]` into `div_a`, `div_b`; latch `g` into `resp_id` and `last`.
- Bypass at accept, when `b[30:0]==0`:
  - If also `a[30:0]==0`, `resp_data=32'h7FC00000` (qNaN).
  - Otherwise `resp_data={a[31]^b[31],8'hFF,23'h0}` (signed infinity).
  - Next state is RESP. EXEC is skipped.
- Non-bypass accept:
  - Load counter with `DIV_LAT-1` and go to EXEC.
- EXEC:
  - `div_a` and `div_b` stay constant.
  - The counter decrements each cycle.
  - At counter==0, capture `div_result` into `resp_data` and go to RESP.
- RESP:
  - `resp_valid=1`, with `resp_data` and `resp_id` held stable until `resp_ready`.
  - On handshake, go to IDLE.
  - No request is accepted in EXEC or RESP, so `req_ready=0` there.
- A requester that drops `req_valid` before its accept loses nothing. Requesters must hold `req_a` and `req_b` stable while valid.

## Timing
- Reset (async assert, sync deassert by the system):
  - state IDLE
  - `last=NREQ-1`, so requester 0 has first priority
  - `req_ready=0` while `rst`
  - `resp_valid=0`, `resp_data=0`, `resp_id=0`
  - `div_a=0`, `div_b=0`, counter 0
- Latency:
  - A normal accept at edge T gives `resp_valid` high in cycle T+DIV_LAT+1.
  - A bypass accept at edge T gives `resp_valid` high in cycle T+1.
- Throughput: the next accept happens earliest in the cycle after the response handshake. With `resp_ready` tied high, that is one request per DIV_LAT+2 cycles.
- Simultaneous requests: the grant goes to the first valid index after `last`. The others wait. No requester waits more than NREQ-1 grants.
- When `resp_ready` is low, RESP holds indefinitely. `div_*` keep their values.
- Reset mid-EXEC or mid-RESP: immediate return to IDLE. The in-flight result is discarded and no response is produced.
- `resp_valid` and `resp_data` are registered outputs. `req_ready` is the only combinational output.

## Structure
- Shared package `fpu_pkg` holds:
  - state enum `fdiv_state_t` {IDLE, EXEC, RESP}
  - constants `FP32_QNAN=32'h7FC00000` and `FP32_EXP_INF=8'hFF`
  - a zero-detect function on bits [30:0]
- One sub-module, `rr_arbiter #(NREQ)`:
  - inputs: `req` vector, `last` pointer
  - output: one-hot `grant`
  - purely combinational
  - reused by other shared FPU units
- The counter, FSM and bypass logic live in `fdiv_scheduler`.

## Test plan
- Reset, then req0 sends A=0x40C00000, B=0x40000000 with `resp_ready=1`, divider model at latency 4. `resp_valid` rises 5 cycles after accept with `resp_data=0x40400000` and `resp_id=0`.
- req0 and req1 both valid continuously for 4 requests. Grants alternate 0,1,0,1 and `resp_id` follows the same order.
- req1 sends A=0xC0000000, B=0x00000000. The bypass gives `resp_data=0xFF800000` one cycle after accept, and `div_a`/`div_b` show no EXEC period. A=0x80000000, B=0x80000000 gives `0x7FC00000`.
- Hold `resp_ready=0` for 10 cycles in RESP. `resp_data` and `resp_id` stay stable, and `req_ready` stays 0 for a pending req0. Release gives a handshake, and req0 is accepted the next cycle.
- Assert `rst` in the 2nd EXEC cycle. `resp_valid` is never asserted for that request. After deassert, req0 has priority and its new request completes normally.
- `div_a` and `div_b` stay constant across all DIV_LAT EXEC cycles while a requester changes its operands after accept.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU sequencing units: FSM encoding, IEEE-754
// single-precision special constants and a magnitude zero-detect helper.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fdiv_state_t;

  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_INF = 8'hFF;

  // True for +0/-0 (sign bit ignored).
  function automatic logic fp32_mag_zero(input logic [31:0] x);
    return (x[30:0] == 31'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requesting
// index after `last`, wrapping modulo NREQ.
module rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant
);

  int unsigned idx;
  logic        hit;

  always_comb begin
    grant = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!hit && req[IDW'(idx)]) begin
        grant[IDW'(idx)] = 1'b1;
        hit              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdiv_scheduler.sv
// Shares one FP32 divider among NREQ requesters: round-robin accept, holds
// operands for DIV_LAT cycles, returns the quotient with the owner's index.
module fdiv_scheduler
  import fpu_pkg::*;
#(
  parameter  int unsigned XLEN    = 32,
  parameter  int unsigned NREQ    = 2,
  parameter  int unsigned DIV_LAT = 4,
  localparam int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  output logic [XLEN-1:0]      div_a,
  output logic [XLEN-1:0]      div_b,
  input  logic [XLEN-1:0]      div_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic [IDW-1:0]       resp_id
);

  localparam int unsigned CNTW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  fdiv_state_t     state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] div_a_q, div_a_d;
  logic [XLEN-1:0] div_b_q, div_b_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic            resp_valid_q, resp_valid_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  sel_id;
  logic [XLEN-1:0] sel_a, sel_b;
  logic            accept;
  logic [XLEN-1:0] a_arr [NREQ];
  logic [XLEN-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*XLEN +: XLEN];
    assign b_arr[g] = req_b[g*XLEN +: XLEN];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // Only combinational output: grant is offered while idle and out of reset.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    sel_id = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[IDW'(i)]) sel_id = IDW'(i);
    end
    sel_a = a_arr[sel_id];
    sel_b = b_arr[sel_id];
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    resp_id_d   = resp_id_q;
    cnt_d       = cnt_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          div_a_d   = sel_a;
          div_b_d   = sel_b;
          resp_id_d = sel_id;
          last_d    = sel_id;
          // x/0 never reaches the divider: answer is NaN or signed infinity.
          if (fp32_mag_zero(sel_b)) begin
            resp_data_d = fp32_mag_zero(sel_a) ? FP32_QNAN
                                               : {sel_a[31] ^ sel_b[31], FP32_EXP_INF, 23'd0};
            state_d     = RESP;
          end else begin
            cnt_d   = CNTW'(DIV_LAT - 1);
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          resp_data_d = div_result;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= IDW'(NREQ - 1);
      resp_id_q    <= '0;
      cnt_q        <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      resp_id_q    <= resp_id_d;
      cnt_q        <= cnt_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_fdiv_scheduler.sv
// Scoreboard bench for fdiv_scheduler with a latency-DIV_LAT divider model
// that only returns a quotient after its operands have been stable long enough.
module tb_fdiv_scheduler;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned DIV_LAT = 4;
  localparam int unsigned IDW     = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [XLEN-1:0]      div_a, div_b, div_result;
  logic                 resp_valid, resp_ready;
  logic [XLEN-1:0]      resp_data;
  logic [IDW-1:0]       resp_id;

  fdiv_scheduler #(.XLEN(XLEN), .NREQ(NREQ), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  // Known quotients for the operand pairs used below.
  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h40000000}: return 32'h3F000000;
      {32'hC1000000, 32'h40800000}: return 32'hC0000000;
      {32'h41200000, 32'h40800000}: return 32'h40200000;
      {32'h41100000, 32'h40400000}: return 32'h40400000;
      {32'h3F800000, 32'h40800000}: return 32'h3E800000;
      default:                      return 32'hBAD0BAD0;
    endcase
  endfunction

  logic [31:0] pa = '0, pb = '0;
  int          stab = 0;
  always @(negedge clk) begin
    if (div_a == pa && div_b == pb) stab++;
    else stab = 1;
    pa = div_a;
    pb = div_b;
  end
  assign div_result = (stab >= DIV_LAT) ? quot(div_a, div_b) : 32'hDEAD0000;

  function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b);
    if (b[30:0] == 31'd0) begin
      if (a[30:0] == 31'd0) return 32'h7FC00000;
      return {a[31] ^ b[31], 8'hFF, 23'd0};
    end
    return quot(a, b);
  endfunction

  function automatic logic [NREQ-1:0] rr_exp(input logic [NREQ-1:0] v, input int l);
    int p;
    logic [NREQ-1:0] g;
    g = '0;
    p = l;
    repeat (NREQ) begin
      p = (p == int'(NREQ) - 1) ? 0 : p + 1;
      if (v[p] && g == '0) g[p] = 1'b1;
    end
    return g;
  endfunction

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    a;
    logic [31:0]    b;
    logic [31:0]    data;
    int             lat;
    int             acc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0;
  int   last_m = NREQ - 1;
  bit   acc_evt, hs_evt;
  int   acc_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Observe what the coming rising edge will do, update the model, advance a cycle.
  task automatic tick();
    exp_t        e;
    logic [NREQ-1:0] hs;
    logic        erv;
    acc_evt = 1'b0;
    hs_evt  = 1'b0;
    #1;
    if (rst) begin
      chk("req_ready_in_rst", 32'(req_ready), 32'd0);
      chk("resp_valid_in_rst", 32'(resp_valid), 32'd0);
      sbq.delete();
      last_m = NREQ - 1;
    end else begin
      chk("req_ready", 32'(req_ready), 32'(sbq.size() != 0 ? '0 : rr_exp(req_valid, last_m)));
      if (sbq.size() != 0) begin
        erv = (cyc - sbq[0].acc) >= sbq[0].lat;
        chk("resp_valid", 32'(resp_valid), 32'(erv));
        chk("div_a_hold", div_a, sbq[0].a);
        chk("div_b_hold", div_b, sbq[0].b);
        if (resp_valid) begin
          chk("resp_data", resp_data, sbq[0].data);
          chk("resp_id", 32'(resp_id), 32'(sbq[0].id));
          if (resp_ready) begin
            void'(sbq.pop_front());
            hs_evt = 1'b1;
          end
        end
      end else begin
        chk("resp_valid_idle", 32'(resp_valid), 32'd0);
      end
      hs = req_valid & req_ready;
      if (hs != '0) begin
        for (int i = 0; i < int'(NREQ); i++) if (hs[i]) acc_id = i;
        e.id   = IDW'(acc_id);
        e.a    = req_a[acc_id*XLEN +: XLEN];
        e.b    = req_b[acc_id*XLEN +: XLEN];
        e.data = exp_res(e.a, e.b);
        e.lat  = (e.b[30:0] == 31'd0) ? 1 : int'(DIV_LAT) + 1;
        e.acc  = cyc;
        sbq.push_back(e);
        last_m  = acc_id;
        acc_evt = 1'b1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b);
    req_valid[id]          = 1'b1;
    req_a[id*XLEN +: XLEN] = a;
    req_b[id*XLEN +: XLEN] = b;
  endtask

  // Present one request, wait for its accept, then scramble the operands.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b);
    bit done;
    done = 1'b0;
    drive(id, a, b);
    for (int t = 0; t < 60 && !done; t++) begin
      tick();
      if (acc_evt && acc_id == id) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    req_valid[id]          = 1'b0;
    req_a[id*XLEN +: XLEN] = ~a;
    req_b[id*XLEN +: XLEN] = ~b;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 60 && sbq.size() != 0; t++) tick();
    if (sbq.size() != 0) chk("idle_timeout", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] na [4];
    logic [31:0] nb [4];
    int          order [4];
    int          cnt;
    bit          seen;

    na = '{32'h41100000, 32'h3F800000, 32'hC1000000, 32'h40C00000};
    nb = '{32'h40400000, 32'h40800000, 32'h40800000, 32'h40000000};
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    rst = 1'b0;
    tick();

    // Basic divide 6/2 from requester 0.
    issue(0, 32'h40C00000, 32'h40000000);
    wait_idle();

    // Bypass cases from requester 1.
    issue(1, 32'hC0000000, 32'h00000000);
    wait_idle();
    issue(1, 32'h80000000, 32'h80000000);
    wait_idle();

    // Both requesters continuously valid: grants must alternate 0,1,0,1.
    drive(0, 32'h41200000, 32'h40800000);
    drive(1, 32'h3F800000, 32'h40000000);
    cnt = 0;
    for (int t = 0; t < 100 && cnt < 4; t++) begin
      tick();
      if (acc_evt) begin
        order[cnt] = acc_id;
        drive(acc_id, na[cnt], nb[cnt]);
        cnt++;
      end
    end
    req_valid = '0;
    chk("rr_accept_count", 32'(cnt), 32'd4);
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
    wait_idle();

    // Consumer stalls for well over 10 cycles while req0 waits with a new request.
    resp_ready = 1'b0;
    issue(0, 32'hC1000000, 32'h40800000);
    drive(0, 32'h3F800000, 32'h40800000);
    repeat (16) tick();
    chk("stall_resp_valid", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      seen = hs_evt;
    end
    chk("stall_handshake", 32'(seen), 32'd1);
    tick();
    chk("accept_after_hs", 32'(acc_evt), 32'd1);
    chk("accept_after_hs_id", 32'(acc_id), 32'd0);
    req_valid[0] = 1'b0;
    wait_idle();

    // Reset during the second EXEC cycle discards the in-flight divide.
    issue(1, 32'h41200000, 32'h40800000);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_div_a", div_a, 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    tick();
    rst = 1'b0;
    repeat (8) tick();

    // After reset requester 0 wins over requester 1.
    drive(0, 32'h3F800000, 32'h40000000);
    drive(1, 32'h41100000, 32'h40400000);
    cnt = 0;
    for (int t = 0; t < 100 && cnt < 2; t++) begin
      tick();
      if (acc_evt) begin
        order[cnt] = acc_id;
        req_valid[acc_id] = 1'b0;
        cnt++;
      end
    end
    chk("post_rst_count", 32'(cnt), 32'd2);
    chk("post_rst_first", 32'(order[0]), 32'd0);
    wait_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
